reg_bank_scheduler: RTL and testbench

//  Shares a bank of NUM_REGS Register32bit-style registers (3-bit FunSel, enable E, 32-bit I) between NUM_REQ requesters.

---
 rtl/reg_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/reg_bank_scheduler.sv | 163 ++++++++++++++++
 tb/tb_reg_bank_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/reg_ctrl_pkg.sv
// Shared definitions for the register-bank control path: FunSel codes,
// scheduler FSM states and burst length.
package reg_ctrl_pkg;

  localparam logic [2:0] FS_DEC    = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOAD   = 3'b010;
  localparam logic [2:0] FS_CLR    = 3'b011;
  localparam logic [2:0] FS_LD8    = 3'b100;
  localparam logic [2:0] FS_LD16   = 3'b101;
  localparam logic [2:0] FS_SHL8   = 3'b110;
  localparam logic [2:0] FS_SEXT16 = 3'b111;

  localparam int unsigned BURST_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BURST = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int unsigned j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/reg_bank_scheduler.sv
// Round-robin scheduler sharing a Register32bit-style bank between requesters;
// single ops take one ISSUE cycle, bursts rebuild a word via four byte shift-loads.
module reg_bank_scheduler
  import reg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned REG_SEL_W = 2
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [3*NUM_REQ-1:0]          ReqOp,
  input  logic [NUM_REQ-1:0]            ReqBurst,
  input  logic [REG_SEL_W*NUM_REQ-1:0]  ReqReg,
  input  logic [32*NUM_REQ-1:0]         ReqData,
  output logic [NUM_REQ-1:0]            Gnt,
  output logic                          Err,
  output logic [NUM_REGS-1:0]           RegE,
  output logic [2:0]                    FunSel,
  output logic [31:0]                   RegI,
  output logic                          Busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam logic [1:0]  LAST_BEAT = 2'(BURST_BEATS - 1);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      win_q, win_d;
  logic [2:0]            op_q, op_d;
  logic [REG_SEL_W-1:0]  sel_q, sel_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            beat_q, beat_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  err_q, err_d;
  logic [NUM_REGS-1:0]   rege_q, rege_d;
  logic [2:0]            funsel_q, funsel_d;
  logic [31:0]           regi_q, regi_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]      arb_idx;
  logic                  arb_valid;
  logic                  drive, done;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(PTR_W)) u_arb (
    .req   (Req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Outputs are computed one cycle ahead so the bank sees them as registers.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    sel_d    = sel_q;
    data_d   = data_q;
    beat_d   = beat_q;
    gnt_d    = '0;
    err_d    = 1'b0;
    rege_d   = '0;
    funsel_d = FS_DEC;
    regi_d   = '0;
    drive    = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_d  = arb_idx;
          op_d   = ReqOp[3*arb_idx +: 3];
          sel_d  = ReqReg[REG_SEL_W*arb_idx +: REG_SEL_W];
          data_d = ReqData[32*arb_idx +: 32];
          beat_d = '0;
          drive  = 1'b1;
          if (|(ReqBurst & arb_gnt)) begin
            state_d  = BURST;
            funsel_d = FS_SHL8;
            regi_d   = {24'b0, data_d[31:24]};
          end else begin
            state_d  = ISSUE;
            funsel_d = op_d;
            regi_d   = data_d;
            done     = 1'b1;
          end
        end
      end
      ISSUE: state_d = IDLE;
      BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
        end else begin
          beat_d   = beat_q + 2'd1;
          drive    = 1'b1;
          funsel_d = FS_SHL8;
          case (beat_d)
            2'd1:    regi_d = {24'b0, data_q[23:16]};
            2'd2:    regi_d = {24'b0, data_q[15:8]};
            default: regi_d = {24'b0, data_q[7:0]};
          endcase
          done = (beat_d == LAST_BEAT);
        end
      end
      default: state_d = IDLE;
    endcase

    if (drive) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) rege_d[i] = (32'(sel_d) == i);
    end
    if (done) begin
      gnt_d[win_d] = 1'b1;
      err_d        = (32'(sel_d) >= NUM_REGS);
      ptr_d        = (win_d == PTR_W'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      op_q     <= '0;
      sel_q    <= '0;
      data_q   <= '0;
      beat_q   <= '0;
      gnt_q    <= '0;
      err_q    <= 1'b0;
      rege_q   <= '0;
      funsel_q <= '0;
      regi_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      beat_q   <= beat_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      rege_q   <= rege_d;
      funsel_q <= funsel_d;
      regi_q   <= regi_d;
      busy_q   <= busy_d;
    end
  end

  assign Gnt    = gnt_q;
  assign Err    = err_q;
  assign RegE   = rege_q;
  assign FunSel = funsel_q;
  assign RegI   = regi_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_reg_bank_scheduler.sv
// Directed bench for reg_bank_scheduler with a behavioural register-bank model
// (NUM_REGS=3 so index 3 exercises the out-of-range path).
module tb_reg_bank_scheduler;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [3:0]    Req, ReqBurst;
  logic [11:0]   ReqOp;
  logic [7:0]    ReqReg;
  logic [127:0]  ReqData;
  logic [3:0]    Gnt;
  logic          Err;
  logic [2:0]    RegE;
  logic [2:0]    FunSel;
  logic [31:0]   RegI;
  logic          Busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] bank [3] = '{default: 32'h0};
  logic [31:0] exp_bank [3];

  reg_bank_scheduler #(.NUM_REQ(4), .NUM_REGS(3), .REG_SEL_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .ReqOp(ReqOp), .ReqBurst(ReqBurst),
    .ReqReg(ReqReg), .ReqData(ReqData), .Gnt(Gnt), .Err(Err), .RegE(RegE),
    .FunSel(FunSel), .RegI(RegI), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    for (int i = 0; i < 3; i++) begin
      if (RegE[i]) begin
        case (FunSel)
          3'b000:  bank[i] <= bank[i] - 32'd1;
          3'b001:  bank[i] <= bank[i] + 32'd1;
          3'b010:  bank[i] <= RegI;
          3'b011:  bank[i] <= 32'h0;
          3'b110:  bank[i] <= {bank[i][23:0], RegI[7:0]};
          default: bank[i] <= bank[i];
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ctl packs {Gnt, Err, RegE, FunSel, Busy}
  task automatic chk_out(input string name, input logic [3:0] g, input logic e,
                         input logic [2:0] re, input logic [2:0] fs,
                         input logic [31:0] ri, input logic b);
    chk({name, " ctl"}, {20'b0, Gnt, Err, RegE, FunSel, Busy}, {20'b0, g, e, re, fs, b});
    chk({name, " RegI"}, RegI, ri);
  endtask

  task automatic chk_bank(input string name);
    for (int i = 0; i < 3; i++) chk($sformatf("%s R%0d", name, i), bank[i], exp_bank[i]);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clr_req();
    Req = '0; ReqBurst = '0; ReqOp = '0; ReqReg = '0; ReqData = '0;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic b,
                         input logic [1:0] r, input logic [31:0] d);
    Req[i]             = 1'b1;
    ReqBurst[i]        = b;
    ReqOp[3*i +: 3]    = op;
    ReqReg[2*i +: 2]   = r;
    ReqData[32*i +: 32] = d;
  endtask

  typedef struct {
    int          rq;
    logic [2:0]  op;
    logic [1:0]  rg;
    logic [31:0] data;
    logic [2:0]  e_rege;
    logic        e_err;
    logic [31:0] e_val;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [31:0] bd;
    int          order [5];

    vt[0] = '{rq: 1, op: 3'b010, rg: 2'd2, data: 32'hDEADBEEF, e_rege: 3'b100, e_err: 1'b0, e_val: 32'hDEADBEEF};
    vt[1] = '{rq: 0, op: 3'b010, rg: 2'd0, data: 32'h00000005, e_rege: 3'b001, e_err: 1'b0, e_val: 32'h00000005};
    vt[2] = '{rq: 3, op: 3'b001, rg: 2'd0, data: 32'hABCD0000, e_rege: 3'b001, e_err: 1'b0, e_val: 32'h00000006};
    vt[3] = '{rq: 2, op: 3'b011, rg: 2'd2, data: 32'h12121212, e_rege: 3'b100, e_err: 1'b0, e_val: 32'h00000000};
    vt[4] = '{rq: 0, op: 3'b010, rg: 2'd3, data: 32'h55555555, e_rege: 3'b000, e_err: 1'b1, e_val: 32'h0};
    vt[5] = '{rq: 1, op: 3'b000, rg: 2'd1, data: 32'h00000000, e_rege: 3'b010, e_err: 1'b0, e_val: 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) exp_bank[i] = 32'h0;

    // Reset and quiet idle
    Reset = 1'b0;
    clr_req();
    tick(); tick();
    chk_out("in_reset", 4'b0, 1'b0, 3'b0, 3'b0, 32'h0, 1'b0);
    Reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out($sformatf("idle%0d", c), 4'b0, 1'b0, 3'b0, 3'b0, 32'h0, 1'b0);
    end

    // Single-op vectors
    for (int v = 0; v < 6; v++) begin
      clr_req();
      set_req(vt[v].rq, vt[v].op, 1'b0, vt[v].rg, vt[v].data);
      tick();
      chk_out($sformatf("vec%0d issue", v), 4'(1 << vt[v].rq), vt[v].e_err, vt[v].e_rege,
              vt[v].op, vt[v].data, 1'b1);
      clr_req();
      tick();
      chk_out($sformatf("vec%0d after", v), 4'b0, 1'b0, 3'b0, 3'b0, 32'h0, 1'b0);
      if (!vt[v].e_err) exp_bank[vt[v].rg] = vt[v].e_val;
      chk_bank($sformatf("vec%0d bank", v));
    end

    // Burst to R0
    bd = 32'h12345678;
    set_req(2, 3'b000, 1'b1, 2'd0, bd);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk_out($sformatf("burst beat%0d", b), (b == 3) ? 4'b0100 : 4'b0000, 1'b0, 3'b001,
              3'b110, {24'b0, bd[31-8*b -: 8]}, 1'b1);
      if (b == 0) clr_req();
    end
    tick();
    chk_out("burst after", 4'b0, 1'b0, 3'b0, 3'b0, 32'h0, 1'b0);
    exp_bank[0] = 32'h12345678;
    chk_bank("burst bank");

    // Burst to R1 (FFFFFFFF) aborted by reset after beat 1
    set_req(1, 3'b000, 1'b1, 2'd1, 32'hAABBCCDD);
    tick();
    chk_out("abort beat0", 4'b0, 1'b0, 3'b010, 3'b110, 32'h000000AA, 1'b1);
    clr_req();
    tick();
    chk_out("abort beat1", 4'b0, 1'b0, 3'b010, 3'b110, 32'h000000BB, 1'b1);
    tick();
    Reset = 1'b0;
    #1;
    chk_out("abort reset", 4'b0, 1'b0, 3'b0, 3'b0, 32'h0, 1'b0);
    tick();
    chk_out("abort held", 4'b0, 1'b0, 3'b0, 3'b0, 32'h0, 1'b0);
    Reset = 1'b1;
    tick();
    chk_out("abort released", 4'b0, 1'b0, 3'b0, 3'b0, 32'h0, 1'b0);
    exp_bank[1] = 32'hFFFFAABB;
    chk_bank("abort bank");

    // All four requesters held: rotation from ptr=0 after reset
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) set_req(i, 3'b010, 1'b0, 2'(i % 3), 32'h100 + i);
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("rr cycle%0d Gnt", c), {28'b0, Gnt},
          (c % 2 == 1) ? 32'(1 << order[(c-1)/2]) : 32'h0);
    end
    clr_req();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
